rf_write_arbiter: RTL and testbench

//  Shares the single register-file write port (WriteEnable/WriteRegister/WriteData)

---
 rtl/rf_write_arbiter.sv | 127 ++++++++++++
 tb/tb_rf_write_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Shares the single register-file write port among NUM_REQ writeback
//   sources (e.g. pipeline WB stage, multi-cycle mul/div unit). Each source
//   uses a valid/ready handshake. The grant is either fixed priority
//   (requester 0 highest) or round-robin. Grants are never given to a source
//   whose valid is low. The accepted write is registered and presented to the
//   register file one cycle after acceptance.
//
// Ports
//   clk         clock, all state updates on posedge
//   rst         asynchronous, active-high reset
//   prio_fixed  1: fixed priority, 0: round-robin (applies in the same cycle)
//   hold        1: grant nothing this cycle
//   req_valid   per-requester write pending
//   req_addr    per-requester destination register, slice [i*AW +: AW]
//   req_data    per-requester write data, slice [i*XLEN +: XLEN]
//   req_ready   one-hot (or zero) grant; a transfer happens on valid & ready
//   wb_en       register file WriteEnable
//   wb_addr     register file WriteRegister
//   wb_data     register file WriteData
//   wb_src      index of the requester that produced the current wb_* values
//   grant_cnt   per-requester 16-bit accepted-transfer counters, slice [i*16 +: 16]
module rf_write_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int XLEN    = 64,
   parameter int AW      = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       prio_fixed,
   input  logic                       hold,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*AW-1:0]      req_addr,
   input  logic [NUM_REQ*XLEN-1:0]    req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       wb_en,
   output logic [AW-1:0]              wb_addr,
   output logic [XLEN-1:0]            wb_data,
   output logic [$clog2(NUM_REQ)-1:0] wb_src,
   output logic [NUM_REQ*16-1:0]      grant_cnt
);

   localparam int PW = $clog2(NUM_REQ);

   logic [PW-1:0]   rr_ptr;
   logic [NUM_REQ-1:0] gnt_p0;
   logic            gnt_any_p0;
   logic [PW-1:0]   gnt_idx_p0;
   logic [AW-1:0]   sel_addr_p0;
   logic [XLEN-1:0] sel_data_p0;
   int              cand;
   logic [PW-1:0]   cand_idx;

   logic            wb_en_p1;
   logic [AW-1:0]   wb_addr_p1;
   logic [XLEN-1:0] wb_data_p1;
   logic [PW-1:0]   wb_src_p1;
   logic [15:0]     cnt_p1 [NUM_REQ];

   // ---- stage p0: grant selection (combinational) ----
   // Fixed mode scans from index 0; round-robin scans from rr_ptr and wraps.
   // The first valid requester in scan order wins.
   always_comb begin
      gnt_p0     = '0;
      gnt_any_p0 = 1'b0;
      gnt_idx_p0 = '0;
      cand       = 0;
      cand_idx   = '0;
      if (!hold) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            cand     = prio_fixed ? k : (int'(rr_ptr) + k) % NUM_REQ;
            cand_idx = PW'(cand);
            if (!gnt_any_p0 && req_valid[cand_idx]) begin
               gnt_any_p0       = 1'b1;
               gnt_idx_p0       = cand_idx;
               gnt_p0[cand_idx] = 1'b1;
            end
         end
      end
   end

   assign req_ready = gnt_p0;

   always_comb begin
      sel_addr_p0 = '0;
      sel_data_p0 = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_p0[i]) begin
            sel_addr_p0 = req_addr[i*AW +: AW];
            sel_data_p0 = req_data[i*XLEN +: XLEN];
         end
      end
   end

   // ---- stage p1: registered write port, pointer and counters ----
   // A write to register 0 is still accepted and counted, but never enabled.
   // Without a transfer only wb_en drops; address/data/source keep last values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_en_p1   <= 1'b0;
         wb_addr_p1 <= '0;
         wb_data_p1 <= '0;
         wb_src_p1  <= '0;
         rr_ptr     <= '0;
         for (int i = 0; i < NUM_REQ; i++) cnt_p1[i] <= '0;
      end else begin
         wb_en_p1 <= gnt_any_p0 && (sel_addr_p0 != '0);
         if (gnt_any_p0) begin
            wb_addr_p1         <= sel_addr_p0;
            wb_data_p1         <= sel_data_p0;
            wb_src_p1          <= gnt_idx_p0;
            cnt_p1[gnt_idx_p0] <= cnt_p1[gnt_idx_p0] + 16'd1;
            rr_ptr             <= (gnt_idx_p0 == PW'(NUM_REQ-1)) ? '0 : gnt_idx_p0 + PW'(1);
         end
      end
   end

   assign wb_en   = wb_en_p1;
   assign wb_addr = wb_addr_p1;
   assign wb_data = wb_data_p1;
   assign wb_src  = wb_src_p1;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
      assign grant_cnt[g*16 +: 16] = cnt_p1[g];
   end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed and randomized bench for rf_write_arbiter (NUM_REQ=2, XLEN=64, AW=5).
module tb_rf_write_arbiter;

   logic         clk;
   logic         rst;
   logic         prio_fixed;
   logic         hold;
   logic [1:0]   req_valid;
   logic [9:0]   req_addr;
   logic [127:0] req_data;
   logic [1:0]   req_ready;
   logic         wb_en;
   logic [4:0]   wb_addr;
   logic [63:0]  wb_data;
   logic [0:0]   wb_src;
   logic [31:0]  grant_cnt;

   int vec;
   int err;

   logic [63:0] rf_d [32];
   logic [63:0] rf_m [32];
   logic        rf_clr;

   rf_write_arbiter #(.NUM_REQ(2), .XLEN(64), .AW(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .prio_fixed (prio_fixed),
      .hold       (hold),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .wb_en      (wb_en),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .wb_src     (wb_src),
      .grant_cnt  (grant_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file image built from the DUT write port.
   always @(posedge clk) begin
      if (rf_clr) begin
         for (int j = 0; j < 32; j++) rf_d[j] <= '0;
      end else if (wb_en) begin
         rf_d[wb_addr] <= wb_data;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst        = 1'b1;
      req_valid  = '0;
      hold       = 1'b0;
      prio_fixed = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      vec++;
      if (wb_en !== 1'b0) begin err++; $display("FAIL reset_wb_en got %b want 0", wb_en); end
      vec++;
      if (wb_addr !== 5'd0 || wb_data !== 64'd0 || wb_src !== 1'b0) begin
         err++; $display("FAIL reset_wb got addr=%0d data=%h src=%0d want 0/0/0", wb_addr, wb_data, wb_src);
      end
      vec++;
      if (grant_cnt !== 32'd0) begin err++; $display("FAIL reset_cnt got %h want 0", grant_cnt); end
      vec++;
      if (req_ready !== 2'b00) begin err++; $display("FAIL reset_ready got %b want 00", req_ready); end
   endtask

   task automatic test_single();
      do_reset();
      req_valid        = 2'b01;
      req_addr[4:0]    = 5'd5;
      req_data[63:0]   = 64'hA5;
      #1;
      vec++;
      if (req_ready !== 2'b01) begin err++; $display("FAIL single_ready got %b want 01", req_ready); end
      @(posedge clk);
      @(negedge clk);
      vec++;
      if (wb_en !== 1'b1 || wb_addr !== 5'd5 || wb_data !== 64'hA5 || wb_src !== 1'b0) begin
         err++; $display("FAIL single_wb got en=%b addr=%0d data=%h src=%0d want 1/5/a5/0", wb_en, wb_addr, wb_data, wb_src);
      end
      req_valid = 2'b00;
      @(posedge clk);
      @(negedge clk);
      vec++;
      if (wb_en !== 1'b0 || wb_addr !== 5'd5 || wb_data !== 64'hA5) begin
         err++; $display("FAIL single_idle got en=%b addr=%0d data=%h want 0/5/a5", wb_en, wb_addr, wb_data);
      end
      vec++;
      if (grant_cnt !== 32'h0000_0001) begin err++; $display("FAIL single_cnt got %h want 00000001", grant_cnt); end
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_r;
      do_reset();
      req_valid        = 2'b11;
      req_addr         = {5'd2, 5'd1};
      req_data         = {64'h2222, 64'h1111};
      for (int c = 0; c < 6; c++) begin
         exp_r = (c % 2 == 0) ? 2'b01 : 2'b10;
         #1;
         vec++;
         if (req_ready !== exp_r) begin err++; $display("FAIL rr_ready[%0d] got %b want %b", c, req_ready, exp_r); end
         @(posedge clk);
         @(negedge clk);
         vec++;
         if (wb_en !== 1'b1 || wb_src !== 1'(c % 2)) begin
            err++; $display("FAIL rr_src[%0d] got en=%b src=%0d want 1/%0d", c, wb_en, wb_src, c % 2);
         end
      end
      vec++;
      if (grant_cnt !== {16'd3, 16'd3}) begin err++; $display("FAIL rr_cnt got %h want 00030003", grant_cnt); end
      req_valid = 2'b00;
   endtask

   task automatic test_fixed();
      do_reset();
      prio_fixed = 1'b1;
      req_valid  = 2'b11;
      req_addr   = {5'd4, 5'd3};
      req_data   = {64'h44, 64'h33};
      for (int c = 0; c < 4; c++) begin
         #1;
         vec++;
         if (req_ready !== 2'b01) begin err++; $display("FAIL fixed_ready[%0d] got %b want 01", c, req_ready); end
         @(posedge clk);
         @(negedge clk);
      end
      vec++;
      if (grant_cnt !== {16'd0, 16'd4}) begin err++; $display("FAIL fixed_cnt got %h want 00000004", grant_cnt); end
      req_valid  = 2'b00;
      prio_fixed = 1'b0;
   endtask

   task automatic test_addr0();
      do_reset();
      req_valid      = 2'b10;
      req_addr[9:5]  = 5'd0;
      req_data[127:64] = 64'hDEAD;
      #1;
      vec++;
      if (req_ready !== 2'b10) begin err++; $display("FAIL addr0_ready got %b want 10", req_ready); end
      @(posedge clk);
      @(negedge clk);
      req_valid = 2'b00;
      vec++;
      if (wb_en !== 1'b0) begin err++; $display("FAIL addr0_wb_en got %b want 0", wb_en); end
      vec++;
      if (grant_cnt !== {16'd1, 16'd0}) begin err++; $display("FAIL addr0_cnt got %h want 00010000", grant_cnt); end
      vec++;
      if (wb_src !== 1'b1) begin err++; $display("FAIL addr0_src got %0d want 1", wb_src); end
   endtask

   task automatic test_hold();
      do_reset();
      req_valid = 2'b01;
      req_addr  = {5'd9, 5'd8};
      req_data  = {64'h99, 64'h88};
      #1;
      vec++;
      if (req_ready !== 2'b01) begin err++; $display("FAIL hold_pre_ready got %b want 01", req_ready); end
      @(posedge clk);
      @(negedge clk);
      vec++;
      if (wb_en !== 1'b1) begin err++; $display("FAIL hold_pre_wb_en got %b want 1", wb_en); end
      req_valid = 2'b11;
      hold      = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         vec++;
         if (req_ready !== 2'b00) begin err++; $display("FAIL hold_ready[%0d] got %b want 00", c, req_ready); end
         @(posedge clk);
         @(negedge clk);
         vec++;
         if (wb_en !== 1'b0 || grant_cnt !== {16'd0, 16'd1}) begin
            err++; $display("FAIL hold_idle[%0d] got en=%b cnt=%h want 0/00000001", c, wb_en, grant_cnt);
         end
      end
      hold = 1'b0;
      #1;
      vec++;
      if (req_ready !== 2'b10) begin err++; $display("FAIL hold_resume_ready got %b want 10", req_ready); end
      @(posedge clk);
      @(negedge clk);
      vec++;
      if (wb_en !== 1'b1 || wb_src !== 1'b1 || wb_addr !== 5'd9) begin
         err++; $display("FAIL hold_resume_wb got en=%b src=%0d addr=%0d want 1/1/9", wb_en, wb_src, wb_addr);
      end
      #1;
      vec++;
      if (req_ready !== 2'b01) begin err++; $display("FAIL hold_next_ready got %b want 01", req_ready); end
      req_valid = 2'b00;
   endtask

   task automatic test_reset_inflight();
      do_reset();
      req_valid      = 2'b01;
      req_addr[4:0]  = 5'd7;
      req_data[63:0] = 64'h77;
      #1;
      vec++;
      if (req_ready !== 2'b01) begin err++; $display("FAIL rstf_ready got %b want 01", req_ready); end
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      vec++;
      if (wb_en !== 1'b1 || grant_cnt !== 32'd1) begin
         err++; $display("FAIL rstf_pre got en=%b cnt=%h want 1/00000001", wb_en, grant_cnt);
      end
      rst = 1'b1;
      #1;
      vec++;
      if (wb_en !== 1'b0 || grant_cnt !== 32'd0 || wb_addr !== 5'd0) begin
         err++; $display("FAIL rstf_clear got en=%b cnt=%h addr=%0d want 0/0/0", wb_en, grant_cnt, wb_addr);
      end
      @(negedge clk);
      rst       = 1'b0;
      req_valid = 2'b11;
      #1;
      vec++;
      if (req_ready !== 2'b01) begin err++; $display("FAIL rstf_ptr got %b want 01", req_ready); end
      req_valid = 2'b00;
   endtask

   task automatic test_random();
      logic        pend  [2];
      logic [4:0]  paddr [2];
      logic [63:0] pdata [2];
      logic [1:0]  exp_r;
      int          rr_m;
      int          eg;
      int          c;
      do_reset();
      rf_clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rf_clr = 1'b0;
      rr_m   = 0;
      for (int i = 0; i < 32; i++) rf_m[i] = '0;
      for (int i = 0; i < 2; i++) begin pend[i] = 1'b0; paddr[i] = '0; pdata[i] = '0; end
      for (int cyc = 0; cyc < 300; cyc++) begin
         for (int i = 0; i < 2; i++) begin
            if (!pend[i] && $urandom_range(1, 0) == 1) begin
               pend[i]  = 1'b1;
               paddr[i] = 5'($urandom_range(31, 0));
               pdata[i] = {$urandom, $urandom};
            end
            req_valid[i]          = pend[i];
            req_addr[i*5 +: 5]    = paddr[i];
            req_data[i*64 +: 64]  = pdata[i];
         end
         prio_fixed = ($urandom_range(3, 0) == 0);
         hold       = ($urandom_range(7, 0) == 0);
         #1;
         eg = -1;
         if (!hold) begin
            for (int k = 0; k < 2; k++) begin
               c = prio_fixed ? k : (rr_m + k) % 2;
               if (eg < 0 && pend[c]) eg = c;
            end
         end
         exp_r = '0;
         if (eg >= 0) exp_r[eg] = 1'b1;
         vec++;
         if (req_ready !== exp_r) begin
            err++; $display("FAIL rand_ready[%0d] got %b want %b", cyc, req_ready, exp_r);
         end
         if (eg >= 0) begin
            if (paddr[eg] != 5'd0) rf_m[paddr[eg]] = pdata[eg];
            pend[eg] = 1'b0;
            rr_m     = (eg + 1) % 2;
         end
         @(posedge clk);
         @(negedge clk);
      end
      req_valid  = 2'b00;
      hold       = 1'b0;
      prio_fixed = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 32; i++) begin
         vec++;
         if (rf_d[i] !== rf_m[i]) begin
            err++; $display("FAIL rand_rf[%0d] got %h want %h", i, rf_d[i], rf_m[i]);
         end
      end
   endtask

   initial begin
      vec        = 0;
      err        = 0;
      rst        = 1'b1;
      rf_clr     = 1'b1;
      prio_fixed = 1'b0;
      hold       = 1'b0;
      req_valid  = '0;
      req_addr   = '0;
      req_data   = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_fixed();
      test_addr0();
      test_hold();
      test_reset_inflight();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
